// File: rtl/multicycle_control_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : multicycle_control_param
// Brief    : Multicycle MIPS control FSM with parametrised memory latency.
// Revision : 1.0
// ============================================================================
module multicycle_control_param #(
    parameter int MEM_LAT = 2               // memory latency in cycles, 1..15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemReadWrite,
    output logic       IRWrite,
    output logic       AluSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       AWrite,
    output logic       BWrite,
    output logic       AluOutWrite,
    output logic       MDRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] AluSrcB,
    output logic [1:0] MemtoReg,
    output logic [2:0] ALUOp,
    output logic [3:0] State_out,
    output logic       Halted,
    output logic       Illegal
);

    localparam logic [3:0] c_FETCH       = 4'd0;
    localparam logic [3:0] c_DECODE      = 4'd1;
    localparam logic [3:0] c_ARIT_EXEC   = 4'd2;
    localparam logic [3:0] c_ARIT_WB     = 4'd3;
    localparam logic [3:0] c_ADDI_EXEC   = 4'd4;
    localparam logic [3:0] c_ADDI_WB     = 4'd5;
    localparam logic [3:0] c_BRANCH      = 4'd6;
    localparam logic [3:0] c_MEM_ADDR    = 4'd7;
    localparam logic [3:0] c_MEM_READ    = 4'd8;
    localparam logic [3:0] c_MEM_READ_WB = 4'd9;
    localparam logic [3:0] c_MEM_WRITE   = 4'd10;
    localparam logic [3:0] c_LUI         = 4'd11;
    localparam logic [3:0] c_JUMP        = 4'd12;
    localparam logic [3:0] c_BREAK       = 4'd13;
    localparam logic [3:0] c_ILLEGAL     = 4'd14;

    localparam logic [2:0] c_ALU_LOAD = 3'd0;
    localparam logic [2:0] c_ALU_ADD  = 3'd1;
    localparam logic [2:0] c_ALU_SUB  = 3'd2;
    localparam logic [2:0] c_ALU_AND  = 3'd3;
    localparam logic [2:0] c_ALU_XOR  = 3'd6;

    localparam logic [3:0] c_CNT_LOAD = 4'(MEM_LAT - 1);

    logic [3:0] r_state;
    logic [3:0] r_cnt;
    logic [3:0] w_next;
    logic       w_last;
    logic       w_enter_mem;

    assign w_last      = (r_cnt == 4'd0);
    assign w_enter_mem = (w_next != r_state) &&
                         ((w_next == c_FETCH) || (w_next == c_MEM_READ) ||
                          (w_next == c_MEM_WRITE));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= c_FETCH;
            r_cnt   <= c_CNT_LOAD;
        end else begin
            r_state <= w_next;
            if (w_enter_mem)
                r_cnt <= c_CNT_LOAD;
            else if (!w_last)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    always_comb begin
        w_next = c_FETCH;
        case (r_state)
            c_FETCH:       w_next = w_last ? c_DECODE : c_FETCH;
            c_DECODE: begin
                case (opcode)
                    6'h00: begin
                        case (funct)
                            6'h20, 6'h22, 6'h24, 6'h26: w_next = c_ARIT_EXEC;
                            6'h00:                      w_next = c_FETCH;
                            6'h0D:                      w_next = c_BREAK;
                            default:                    w_next = c_ILLEGAL;
                        endcase
                    end
                    6'h08:        w_next = c_ADDI_EXEC;
                    6'h04, 6'h05: w_next = c_BRANCH;
                    6'h23, 6'h2B: w_next = c_MEM_ADDR;
                    6'h0F:        w_next = c_LUI;
                    6'h02:        w_next = c_JUMP;
                    default:      w_next = c_ILLEGAL;
                endcase
            end
            c_ARIT_EXEC:   w_next = c_ARIT_WB;
            c_ADDI_EXEC:   w_next = c_ADDI_WB;
            c_MEM_ADDR:    w_next = (opcode == 6'h23) ? c_MEM_READ : c_MEM_WRITE;
            c_MEM_READ:    w_next = w_last ? c_MEM_READ_WB : c_MEM_READ;
            c_MEM_WRITE:   w_next = w_last ? c_FETCH : c_MEM_WRITE;
            c_BREAK:       w_next = c_BREAK;
            c_ILLEGAL:     w_next = c_ILLEGAL;
            default:       w_next = c_FETCH;
        endcase
    end

    // Outputs are forced low while reset is held, independent of r_state.
    always_comb begin
        PCWrite      = 1'b0;
        IorD         = 1'b0;
        MemReadWrite = 1'b0;
        IRWrite      = 1'b0;
        AluSrcA      = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        AWrite       = 1'b0;
        BWrite       = 1'b0;
        AluOutWrite  = 1'b0;
        MDRWrite     = 1'b0;
        PCSource     = 2'b00;
        AluSrcB      = 2'b00;
        MemtoReg     = 2'b00;
        ALUOp        = c_ALU_LOAD;
        State_out    = 4'd0;
        Halted       = 1'b0;
        Illegal      = 1'b0;
        if (reset) begin
            State_out = r_state;
            case (r_state)
                c_FETCH: begin
                    AluSrcB = 2'b01;
                    ALUOp   = c_ALU_ADD;
                    IRWrite = w_last;
                    PCWrite = w_last;
                end
                c_DECODE: begin
                    AluSrcB     = 2'b11;
                    ALUOp       = c_ALU_ADD;
                    AWrite      = 1'b1;
                    BWrite      = 1'b1;
                    AluOutWrite = 1'b1;
                end
                c_ARIT_EXEC: begin
                    AluSrcA     = 1'b1;
                    AluOutWrite = 1'b1;
                    case (funct)
                        6'h20:   ALUOp = c_ALU_ADD;
                        6'h22:   ALUOp = c_ALU_SUB;
                        6'h24:   ALUOp = c_ALU_AND;
                        6'h26:   ALUOp = c_ALU_XOR;
                        default: ALUOp = c_ALU_LOAD;
                    endcase
                end
                c_ARIT_WB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                c_ADDI_EXEC, c_MEM_ADDR: begin
                    AluSrcA     = 1'b1;
                    AluSrcB     = 2'b10;
                    ALUOp       = c_ALU_ADD;
                    AluOutWrite = 1'b1;
                end
                c_ADDI_WB: RegWrite = 1'b1;
                c_BRANCH: begin
                    AluSrcA  = 1'b1;
                    ALUOp    = c_ALU_SUB;
                    PCSource = 2'b01;
                    PCWrite  = ((opcode == 6'h04) && Zero) ||
                               ((opcode == 6'h05) && !Zero);
                end
                c_MEM_READ: begin
                    IorD     = 1'b1;
                    MDRWrite = w_last;
                end
                c_MEM_READ_WB: begin
                    MemtoReg = 2'b01;
                    RegWrite = 1'b1;
                end
                c_MEM_WRITE: begin
                    IorD         = 1'b1;
                    MemReadWrite = 1'b1;
                end
                c_LUI: begin
                    MemtoReg = 2'b10;
                    RegWrite = 1'b1;
                end
                c_JUMP: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                end
                c_BREAK:   Halted  = 1'b1;
                c_ILLEGAL: Illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_param
// Brief    : Directed bench over four instances with MEM_LAT = 2, 4, 1, 3.
// Revision : 1.0
// ============================================================================
module tb_multicycle_control_param;

    logic       clk = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct  = 6'h00;
    logic       zero   = 1'b0;
    logic       rstn [4];
    logic       pcw [4], iord [4], mrw [4], irw [4], asa [4], rw [4];
    logic       rd [4], aw [4], bw [4], aow [4], mdrw [4], hlt [4], ill [4];
    logic [1:0] pcs [4], asb [4], m2r [4];
    logic [2:0] aluop [4];
    logic [3:0] st [4];
    int         vecs = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    // Instance g runs with MEM_LAT 2, 4, 1, 3 for g = 0..3.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 3;
        multicycle_control_param #(.MEM_LAT(LAT)) u_dut (
            .clock(clk), .reset(rstn[g]), .opcode(opcode), .funct(funct),
            .Zero(zero), .PCWrite(pcw[g]), .IorD(iord[g]),
            .MemReadWrite(mrw[g]), .IRWrite(irw[g]), .AluSrcA(asa[g]),
            .RegWrite(rw[g]), .RegDst(rd[g]), .AWrite(aw[g]), .BWrite(bw[g]),
            .AluOutWrite(aow[g]), .MDRWrite(mdrw[g]), .PCSource(pcs[g]),
            .AluSrcB(asb[g]), .MemtoReg(m2r[g]), .ALUOp(aluop[g]),
            .State_out(st[g]), .Halted(hlt[g]), .Illegal(ill[g])
        );
    end

    function automatic logic [25:0] pack(input int i);
        return {pcw[i], iord[i], mrw[i], irw[i], asa[i], rw[i], rd[i], aw[i],
                bw[i], aow[i], mdrw[i], pcs[i], asb[i], m2r[i], aluop[i],
                st[i], hlt[i], ill[i]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Leaves reset low for n rising edges; caller releases after its next cyc().
    task automatic do_reset(input int i, input int n);
        cyc();
        rstn[i] = 1'b0;
        repeat (n - 1) cyc();
    endtask

    task automatic test_reset_add();
        int   est [6] = '{0, 0, 1, 2, 3, 0};
        logic eir [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 6'h00; funct = 6'h20; zero = 1'b0;
        cyc(); rstn[0] = 1'b0;
        smp(); vecs++;
        if (pack(0) !== 26'd0) begin errs++; $display("FAIL reset_outs0: got %h want 0", pack(0)); end
        cyc(); smp(); vecs++;
        if (pack(0) !== 26'd0) begin errs++; $display("FAIL reset_outs1: got %h want 0", pack(0)); end
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (k == 0) rstn[0] = 1'b1;
            smp(); vecs++;
            if (st[0] !== 4'(est[k]) || irw[0] !== eir[k] || pcw[0] !== eir[k]) begin
                errs++;
                $display("FAIL add_cyc%0d: got st=%0d ir=%b pc=%b want st=%0d ir=pc=%b",
                         k + 1, st[0], irw[0], pcw[0], est[k], eir[k]);
            end
            if (k == 3) begin
                vecs++;
                if (aluop[0] !== 3'd1) begin errs++; $display("FAIL add_aluop: got %0d want 1", aluop[0]); end
            end
            if (k == 4) begin
                vecs++;
                if (rw[0] !== 1'b1 || rd[0] !== 1'b1) begin
                    errs++; $display("FAIL add_wb: got rw=%b rd=%b want 1 1", rw[0], rd[0]);
                end
            end
        end
    endtask

    task automatic test_lw_sw();
        int elw [11] = '{0, 0, 0, 0, 1, 7, 8, 8, 8, 8, 9};
        int esw [10] = '{0, 0, 0, 0, 1, 7, 10, 10, 10, 10};
        int nwr = 0;
        opcode = 6'h23;
        do_reset(1, 2);
        for (int k = 0; k < 11; k++) begin
            cyc();
            if (k == 0) rstn[1] = 1'b1;
            smp(); vecs++;
            if (st[1] !== 4'(elw[k]) || mdrw[1] !== (k == 9)) begin
                errs++;
                $display("FAIL lw_cyc%0d: got st=%0d mdr=%b want st=%0d mdr=%b",
                         k + 1, st[1], mdrw[1], elw[k], (k == 9));
            end
        end
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k == 0) opcode = 6'h2B;
            smp(); vecs++;
            if (mrw[1] === 1'b1) nwr++;
            if (st[1] !== 4'(esw[k])) begin
                errs++; $display("FAIL sw_cyc%0d: got st=%0d want %0d", k + 1, st[1], esw[k]);
            end
        end
        vecs++;
        if (nwr != 4) begin errs++; $display("FAIL sw_wrcount: got %0d want 4", nwr); end
        cyc(); smp(); vecs++;
        if (st[1] !== 4'd0) begin errs++; $display("FAIL sw_done: got st=%0d want 0", st[1]); end
    endtask

    task automatic test_branch();
        int eb [4] = '{0, 0, 1, 6};
        logic epw [3] = '{1'b1, 1'b0, 1'b1};
        logic [5:0] ops [3] = '{6'h04, 6'h05, 6'h05};
        logic zs [3] = '{1'b1, 1'b1, 1'b0};
        opcode = 6'h04; zero = 1'b1;
        do_reset(0, 2);
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++) begin
                cyc();
                if (k == 0) begin rstn[0] = 1'b1; opcode = ops[b]; zero = zs[b]; end
                smp(); vecs++;
                if (st[0] !== 4'(eb[k])) begin
                    errs++; $display("FAIL br%0d_cyc%0d: got st=%0d want %0d", b, k + 1, st[0], eb[k]);
                end
                if (k == 3) begin
                    vecs++;
                    if (pcw[0] !== epw[b] || pcs[0] !== 2'b01) begin
                        errs++;
                        $display("FAIL br%0d_pc: got pcw=%b pcs=%b want pcw=%b pcs=01",
                                 b, pcw[0], pcs[0], epw[b]);
                    end
                end
            end
        end
        cyc(); smp(); vecs++;
        if (st[0] !== 4'd0) begin errs++; $display("FAIL br_done: got st=%0d want 0", st[0]); end
    endtask

    task automatic test_illegal_break();
        int e3 [3] = '{0, 0, 1};
        opcode = 6'h3F; funct = 6'h00;
        do_reset(0, 2);
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (k == 0) rstn[0] = 1'b1;
            smp(); vecs++;
            if (st[0] !== 4'(e3[k])) begin errs++; $display("FAIL ill_cyc%0d: got st=%0d want %0d", k + 1, st[0], e3[k]); end
        end
        for (int k = 0; k < 20; k++) begin
            cyc(); smp(); vecs++;
            if (pack(0) !== 26'd57) begin errs++; $display("FAIL ill_hold%0d: got %h want 39", k, pack(0)); end
        end
        cyc(); rstn[0] = 1'b0;
        smp(); vecs++;
        if (pack(0) !== 26'd0) begin errs++; $display("FAIL ill_rst: got %h want 0", pack(0)); end
        cyc(); smp();
        cyc(); rstn[0] = 1'b1; opcode = 6'h00; funct = 6'h0D;
        smp(); vecs++;
        if (st[0] !== 4'd0 || hlt[0] !== 1'b0 || ill[0] !== 1'b0) begin
            errs++; $display("FAIL ill_clear: got st=%0d h=%b i=%b want 0 0 0", st[0], hlt[0], ill[0]);
        end
        cyc(); smp();
        cyc(); smp(); vecs++;
        if (st[0] !== 4'd1) begin errs++; $display("FAIL brk_dec: got st=%0d want 1", st[0]); end
        for (int k = 0; k < 20; k++) begin
            cyc(); smp(); vecs++;
            if (pack(0) !== 26'd54) begin errs++; $display("FAIL brk_hold%0d: got %h want 36", k, pack(0)); end
        end
        cyc(); rstn[0] = 1'b0;
        smp(); cyc(); cyc(); rstn[0] = 1'b1;
        smp(); vecs++;
        if (st[0] !== 4'd0 || hlt[0] !== 1'b0 || ill[0] !== 1'b0) begin
            errs++; $display("FAIL brk_clear: got st=%0d h=%b i=%b want 0 0 0", st[0], hlt[0], ill[0]);
        end
    endtask

    task automatic test_back_to_back_lat1();
        logic [5:0] ops [11] = '{6'h0F, 6'h0F, 6'h0F, 6'h02, 6'h02, 6'h02,
                                 6'h08, 6'h08, 6'h08, 6'h08, 6'h08};
        int est [11] = '{0, 1, 11, 0, 1, 12, 0, 1, 4, 5, 0};
        opcode = 6'h0F;
        do_reset(2, 2);
        for (int k = 0; k < 11; k++) begin
            cyc();
            if (k == 0) rstn[2] = 1'b1;
            opcode = ops[k];
            smp(); vecs++;
            if (st[2] !== 4'(est[k])) begin
                errs++; $display("FAIL b2b_cyc%0d: got st=%0d want %0d", k + 1, st[2], est[k]);
            end
            if (k == 0) begin
                vecs++;
                if (irw[2] !== 1'b1 || pcw[2] !== 1'b1) begin errs++; $display("FAIL b2b_fetch: got ir=%b pc=%b want 1 1", irw[2], pcw[2]); end
            end
            if (k == 2) begin
                vecs++;
                if (m2r[2] !== 2'b10 || rw[2] !== 1'b1) begin errs++; $display("FAIL b2b_lui: got m2r=%b rw=%b want 10 1", m2r[2], rw[2]); end
            end
            if (k == 5) begin
                vecs++;
                if (pcs[2] !== 2'b10 || pcw[2] !== 1'b1) begin errs++; $display("FAIL b2b_jump: got pcs=%b pcw=%b want 10 1", pcs[2], pcw[2]); end
            end
            if (k == 8) begin
                vecs++;
                if (asb[2] !== 2'b10 || aow[2] !== 1'b1) begin errs++; $display("FAIL b2b_addi: got asb=%b aow=%b want 10 1", asb[2], aow[2]); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int e6 [6] = '{0, 0, 0, 1, 7, 8};
        int er [4] = '{0, 0, 0, 1};
        int nmdr = 0;
        opcode = 6'h23;
        do_reset(3, 2);
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (k == 0) rstn[3] = 1'b1;
            smp(); vecs++;
            if (mdrw[3] === 1'b1) nmdr++;
            if (st[3] !== 4'(e6[k])) begin errs++; $display("FAIL mid_cyc%0d: got st=%0d want %0d", k + 1, st[3], e6[k]); end
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            if (k == 0) rstn[3] = 1'b0;
            smp(); vecs++;
            if (mdrw[3] === 1'b1) nmdr++;
            if (pack(3) !== 26'd0) begin errs++; $display("FAIL mid_rst%0d: got %h want 0", k, pack(3)); end
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 0) rstn[3] = 1'b1;
            smp(); vecs++;
            if (mdrw[3] === 1'b1) nmdr++;
            if (st[3] !== 4'(er[k]) || irw[3] !== (k == 2)) begin
                errs++; $display("FAIL mid_refetch%0d: got st=%0d ir=%b want st=%0d ir=%b", k + 1, st[3], irw[3], er[k], (k == 2));
            end
        end
        vecs++;
        if (nmdr != 0) begin errs++; $display("FAIL mid_mdr: got %0d pulses want 0", nmdr); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rstn[i] = 1'b0;
        test_reset_add();
        test_lw_sw();
        test_branch();
        test_illegal_break();
        test_back_to_back_lat1();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_param.md
# multicycle_control_param

Parametrised multicycle MIPS control unit driving the existing datapath (PC, IR, A/B, ALUOut, MDR, register file, unified memory). It generalises the current control FSM: memory latency is a parameter, handled by a wait counter instead of hard-coded wait states. It adds addi, beq/bne (using the ALU zero flag), deterministic outputs in every state, and sticky break/illegal-opcode status outputs.

## Interface
- MEM_LAT, 2, memory access latency in cycles (1..15); applies to instruction fetch, load and store
- clock  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag, sampled combinationally in BRANCH
- PCWrite, IorD, MemReadWrite, IRWrite, AluSrcA, RegWrite, RegDst, AWrite, BWrite, AluOutWrite, MDRWrite  out  1 each  datapath strobes/selects (MemReadWrite: 0 read, 1 write)
- PCSource, AluSrcB, MemtoReg  out  2 each  mux selects
- ALUOp  out  3  LOAD=0, ADD=1, SUB=2, AND=3, INC=4, NEG=5, XOR=6, COMP=7
- State_out  out  4  current state encoding
- Halted  out  1  high while in BREAK
- Illegal  out  1  high while in ILLEGAL

## Operation
- States/encodings: FETCH=0, DECODE=1, ARIT_EXEC=2, ARIT_WB=3, ADDI_EXEC=4, ADDI_WB=5, BRANCH=6, MEM_ADDR=7, MEM_READ=8, MEM_READ_WB=9, MEM_WRITE=10, LUI=11, JUMP=12, BREAK=13, ILLEGAL=14. Code 15 is unused and goes to FETCH.
- Every output is 0 in every state unless listed below. No x assignments.
- Wait counter (4 bits): loaded with MEM_LAT-1 on entry to FETCH, MEM_READ or MEM_WRITE, then decrements each cycle. The state is left when the counter is 0 ("last cycle").
- FETCH: IorD=0, MemReadWrite=0, AluSrcA=0, AluSrcB=01, ALUOp=ADD, PCSource=00. IRWrite=1 and PCWrite=1 on the last cycle only. Next state: DECODE.
- DECODE: AluSrcA=0, AluSrcB=11, ALUOp=ADD, AWrite=1, BWrite=1, AluOutWrite=1 (branch target). Dispatch:
  - opcode 0x00: funct 0x20/0x22/0x24/0x26 to ARIT_EXEC; funct 0x00 (nop) to FETCH; funct 0x0D to BREAK; any other funct to ILLEGAL.
  - 0x08 to ADDI_EXEC; 0x04/0x05 to BRANCH; 0x23/0x2B to MEM_ADDR; 0x0F to LUI; 0x02 to JUMP; any other opcode to ILLEGAL.
- ARIT_EXEC: AluSrcA=1, AluSrcB=00, AluOutWrite=1, ALUOp from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x26 XOR.
- ARIT_WB: RegDst=1, MemtoReg=00, RegWrite=1. Next state: FETCH.
- ADDI_EXEC: AluSrcA=1, AluSrcB=10, ALUOp=ADD, AluOutWrite=1. ADDI_WB: RegDst=0, MemtoReg=00, RegWrite=1. Next state: FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, ALUOp=SUB, PCSource=01. PCWrite=Zero for opcode 0x04, PCWrite=~Zero for 0x05. Next state: FETCH.
- MEM_ADDR: AluSrcA=1, AluSrcB=10, ALUOp=ADD, AluOutWrite=1. Next state: MEM_READ if opcode 0x23, else MEM_WRITE.
- MEM_READ: IorD=1, MemReadWrite=0; MDRWrite=1 on the last cycle only. Next state: MEM_READ_WB.
- MEM_READ_WB: RegDst=0, MemtoReg=01, RegWrite=1. Next state: FETCH.
- MEM_WRITE: IorD=1, MemReadWrite=1 for all MEM_LAT cycles. Next state: FETCH.
- LUI: RegDst=0, MemtoReg=10, RegWrite=1. JUMP: PCSource=10, PCWrite=1. Both go to FETCH.
- BREAK and ILLEGAL are absorbing: all strobes 0, Halted or Illegal respectively held at 1. Only reset exits.

## Timing
- Reset: while reset=0 at a rising edge, the state becomes FETCH and the counter becomes MEM_LAT-1. All outputs are gated to 0 combinationally while reset=0, so State_out=0 and Halted=Illegal=0.
- The first fetch strobe appears in the first cycle with reset=1.
- Reset mid-instruction (including mid-wait) aborts with no further strobes. Writes already committed remain.
- Instruction latency in cycles:
  - add/sub/and/xor: MEM_LAT+3
  - addi: MEM_LAT+3
  - beq/bne: MEM_LAT+2
  - lw: 2·MEM_LAT+3
  - sw: 2·MEM_LAT+2
  - lui, j, nop: MEM_LAT+2 (nop: MEM_LAT+1)
- MEM_LAT=1: the counter loads 0, so each memory state lasts exactly one cycle and the last-cycle strobes fire immediately.
- opcode/funct are assumed stable from DECODE until the return to FETCH. IR is written only in FETCH.

## Test plan
- MEM_LAT=2, reset low 2 cycles then add (op 0x00, funct 0x20): State_out 0,0,1,2,3,0. IRWrite and PCWrite high in cycle 2 only. RegWrite=RegDst=1 in ARIT_WB. ALUOp=1 in ARIT_EXEC.
- MEM_LAT=4, lw (0x23) then sw (0x2B): lw takes 11 cycles with MDRWrite only in the 4th MEM_READ cycle. sw takes 10 cycles with MemReadWrite=1 for exactly 4 cycles.
- MEM_LAT=2, beq with Zero=1 gives PCWrite=1, PCSource=01 in BRANCH. bne with Zero=1 gives PCWrite=0. Both take 4 cycles.
- Opcode 0x3F, then funct 0x0D with opcode 0: Illegal=1 and State_out=14 held for 20 cycles; next run Halted=1 and State_out=13 held. Reset low returns to State_out=0 with both status outputs cleared.
- MEM_LAT=1, lui, j, addi back-to-back: 3, 3, 4 cycles. MemtoReg=10 in LUI, PCSource=10 in JUMP, AluSrcB=10 in ADDI_EXEC.
- Reset asserted in the 2nd MEM_READ cycle (MEM_LAT=3): MDRWrite never pulses and all outputs are 0 while reset is low. Fetch restarts cleanly after release.
